// File: rtl/latsnq_bank_wrctl_pkg.sv
// Shared types and helpers for the latsnq bank write controller.
package latsnq_bank_wrctl_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StPreset,
        StRecov
    } state_e;

    // Cycle counts of zero would never reach the exit value, so map them to 1.
    function automatic logic [CNT_W-1:0] clamp1(input int unsigned n);
        if (n == 0) begin
            return {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return n[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/latsnq_bank_wrctl_cnt.sv
// Loadable down-counter that times each controller state; done when it reaches 1.
module latsnq_bank_wrctl_cnt
    import latsnq_bank_wrctl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RstVal = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] One = 1;

    logic [CNT_W-1:0] cnt_q;

    // Load on state entry, otherwise count down and park at 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RstVal;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q > One) begin
            cnt_q <= cnt_q - One;
        end
    end

    assign done_o = (cnt_q == One);

endmodule

// File: rtl/latsnq_bank_wrctl.sv
// Write controller for a bank of latsnq latches: sequences D, per-bit E pulses
// and bank-wide SETN presets so the latch timing checks are always met.
// Optional readback checker enabled by defining LATSNQ_BANK_WRCTL_CHECK_EN.
module latsnq_bank_wrctl
    import latsnq_bank_wrctl_pkg::*;
#(
    parameter int unsigned NLAT      = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PW_CYC    = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned SETW_CYC  = 2,
    parameter int unsigned REC_CYC   = 2
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [NLAT-1:0] wr_data,
    input  logic [NLAT-1:0] wr_mask,
    input  logic            set_req,
    output logic            set_done,
    output logic [NLAT-1:0] lat_d,
    output logic [NLAT-1:0] lat_e,
`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
    input  logic [NLAT-1:0] lat_q,
    output logic            chk_err,
`endif
    output logic            lat_setn
);

    localparam logic [CNT_W-1:0] SetupC = clamp1(SETUP_CYC);
    localparam logic [CNT_W-1:0] PwC    = clamp1(PW_CYC);
    localparam logic [CNT_W-1:0] HoldC  = clamp1(HOLD_CYC);
    localparam logic [CNT_W-1:0] SetwC  = clamp1(SETW_CYC);
    localparam logic [CNT_W-1:0] RecC   = clamp1(REC_CYC);

    state_e           state_q, state_d;
    logic             cnt_load, cnt_done, accept;
    logic [CNT_W-1:0] cnt_val;
    logic [NLAT-1:0]  lat_d_q, lat_e_q, mask_q;
    logic             lat_setn_q, wr_ready_q, set_done_q, from_set_q;

    latsnq_bank_wrctl_cnt #(
        .RstVal (RecC)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_ni     (RN),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    // Next-state decode; set_req wins over a write in IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (set_req) begin
                    state_d = StPreset;
                end else if (wr_valid) begin
                    state_d = StSetup;
                    accept  = 1'b1;
                end
            end
            StSetup:  if (cnt_done) state_d = StPulse;
            StPulse:  if (cnt_done) state_d = StHold;
            StHold:   if (cnt_done) state_d = StIdle;
            StPreset: if (cnt_done) state_d = StRecov;
            StRecov:  if (cnt_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Counter reload value for the state being entered.
    always_comb begin
        cnt_load = (state_d != state_q);
        cnt_val  = {{(CNT_W-1){1'b0}}, 1'b1};
        unique case (state_d)
            StSetup:  cnt_val = SetupC;
            StPulse:  cnt_val = PwC;
            StHold:   cnt_val = HoldC;
            StPreset: cnt_val = SetwC;
            StRecov:  cnt_val = RecC;
            default:  cnt_val = {{(CNT_W-1){1'b0}}, 1'b1};
        endcase
    end

    // State and registered outputs; reset holds the bank in preset.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= StRecov;
            lat_d_q    <= '0;
            lat_e_q    <= '0;
            mask_q     <= '0;
            lat_setn_q <= 1'b0;
            wr_ready_q <= 1'b0;
            set_done_q <= 1'b0;
            from_set_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (accept) begin
                lat_d_q <= wr_data;
                mask_q  <= wr_mask;
            end
            lat_e_q    <= (state_d == StPulse) ? mask_q : '0;
            lat_setn_q <= (state_d != StPreset);
            wr_ready_q <= (state_d == StIdle);
            set_done_q <= (state_q == StRecov) && (state_d == StIdle) && from_set_q;
            if (state_d == StPreset) begin
                from_set_q <= 1'b1;
            end else if (state_d == StIdle) begin
                from_set_q <= 1'b0;
            end
        end
    end

`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
    logic chk_err_q;

    // Sticky readback check at the end of HOLD and after a preset's recovery.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            chk_err_q <= 1'b0;
        end else begin
            if ((state_q == StHold) && cnt_done && |((lat_q ^ lat_d_q) & mask_q)) begin
                chk_err_q <= 1'b1;
            end
            if ((state_q == StRecov) && cnt_done && from_set_q && (lat_q != '1)) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_err_q;
`endif

    assign lat_d    = lat_d_q;
    assign lat_e    = lat_e_q;
    assign lat_setn = lat_setn_q;
    assign wr_ready = wr_ready_q;
    assign set_done = set_done_q;

endmodule

// File: tb/tb_latsnq_bank_wrctl.sv
// Self-checking bench for latsnq_bank_wrctl with a behavioural latch bank model.
module tb_latsnq_bank_wrctl;

    localparam int S  = 2;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int SW = 2;
    localparam int R  = 2;

    logic       CLK = 1'b0;
    logic       RN;
    logic       wr_valid, wr_ready, set_req, set_done, lat_setn;
    logic [7:0] wr_data, wr_mask, lat_d, lat_e;
    logic [7:0] mq = 8'hFF;
    logic [7:0] q_ref;
    int         checks = 0;
    int         errors = 0;
    int         viol = 0;

`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
    logic       stuck = 1'b0;
    logic [7:0] lat_q;
    logic       chk_err;
    assign lat_q = mq & (stuck ? 8'hFB : 8'hFF);
`endif

    latsnq_bank_wrctl dut (
        .CLK      (CLK),
        .RN       (RN),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .set_req  (set_req),
        .set_done (set_done),
        .lat_d    (lat_d),
        .lat_e    (lat_e),
`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
        .lat_q    (lat_q),
        .chk_err  (chk_err),
`endif
        .lat_setn (lat_setn)
    );

    always #5 CLK = ~CLK;

    // Latch bank: SETN low forces 1, E high is transparent.
    always @(lat_setn or lat_e or lat_d) begin
        for (int i = 0; i < 8; i++) begin
            if (!lat_setn) mq[i] = 1'b1;
            else if (lat_e[i]) mq[i] = lat_d[i];
        end
    end

    // Timing-check notifier: setup, hold, recovery and E-during-preset.
    int         d_age = 100, f_age = 100, s_age = 100;
    logic [7:0] pd = 8'h00, pe = 8'h00;
    logic       ps = 1'b0;
    always @(negedge CLK) begin
        if (RN) begin
            d_age = (d_age < 100) ? d_age + 1 : d_age;
            f_age = (f_age < 100) ? f_age + 1 : f_age;
            s_age = (s_age < 100) ? s_age + 1 : s_age;
            if (lat_d != pd) begin
                if (pe != 0 || lat_e != 0 || f_age < H) viol++;
                d_age = 0;
            end
            if ((lat_e & ~pe) != 0 && (d_age < S || s_age < R)) viol++;
            if (lat_e != 0 && !lat_setn) viol++;
            if (pe != 0 && lat_e == 0) f_age = 0;
            if (lat_setn && !ps) s_age = 0;
        end
        pd = lat_d;
        pe = lat_e;
        ps = lat_setn;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (!wr_ready && n < budget) begin
            tick();
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL %s wr_ready timeout after %0d cycles", name, budget);
        end
    endtask

    // Accept one write and check the whole E/ready timeline against the model.
    task automatic do_write(input logic [7:0] data, input logic [7:0] mask, input string name);
        logic [7:0] e_exp;
        logic       r_exp;
        wait_ready(20, name);
        wr_valid = 1'b1;
        wr_data  = data;
        wr_mask  = mask;
        tick();
        wr_valid = 1'b0;
        wr_data  = $urandom;
        wr_mask  = $urandom;
        for (int k = 0; k <= S + P + H; k++) begin
            if (k > 0) tick();
            e_exp = (k >= S && k < S + P) ? mask : 8'h00;
            r_exp = (k == S + P + H);
            checks++;
            if (lat_e !== e_exp || lat_d !== data || wr_ready !== r_exp || lat_setn !== 1'b1) begin
                errors++;
                $display("FAIL %s k=%0d e=%h/%h d=%h/%h rdy=%b/%b setn=%b/1", name, k,
                         lat_e, e_exp, lat_d, data, wr_ready, r_exp, lat_setn);
            end
        end
        q_ref = (q_ref & ~mask) | (data & mask);
        checks++;
        if (mq !== q_ref) begin
            errors++;
            $display("FAIL %s bank_q got %h exp %h", name, mq, q_ref);
        end
    endtask

    // Issue a preset (wr_valid left as the caller set it) and check SETN timeline.
    task automatic do_preset(input string name);
        logic [7:0] d_before;
        logic       s_exp, r_exp;
        wait_ready(20, name);
        d_before = lat_d;
        set_req  = 1'b1;
        tick();
        for (int k = 0; k <= SW + R; k++) begin
            if (k > 0) tick();
            s_exp = (k >= SW);
            r_exp = (k == SW + R);
            checks++;
            if (lat_setn !== s_exp || set_done !== r_exp || wr_ready !== r_exp ||
                lat_e !== 8'h00 || lat_d !== d_before) begin
                errors++;
                $display("FAIL %s k=%0d setn=%b/%b done=%b/%b rdy=%b/%b e=%h d=%h/%h", name, k,
                         lat_setn, s_exp, set_done, r_exp, wr_ready, r_exp, lat_e, lat_d,
                         d_before);
            end
        end
        set_req = 1'b0;
        q_ref   = 8'hFF;
        checks++;
        if (mq !== q_ref) begin
            errors++;
            $display("FAIL %s bank_q got %h exp %h", name, mq, q_ref);
        end
    endtask

    task automatic test_reset();
        RN       = 1'b0;
        wr_valid = 1'b0;
        set_req  = 1'b0;
        wr_data  = 8'h00;
        wr_mask  = 8'h00;
        repeat (3) tick();
        checks++;
        if (lat_setn !== 1'b0 || lat_e !== 8'h00 || lat_d !== 8'h00 || wr_ready !== 1'b0 ||
            set_done !== 1'b0 || mq !== 8'hFF) begin
            errors++;
            $display("FAIL reset_values setn=%b e=%h d=%h rdy=%b done=%b q=%h", lat_setn,
                     lat_e, lat_d, wr_ready, set_done, mq);
        end
`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_chk_err got %b exp 0", chk_err);
        end
`endif
        #2 RN = 1'b1;
        for (int k = 1; k <= R; k++) begin
            tick();
            checks++;
            if (lat_setn !== 1'b1 || wr_ready !== (k == R) || set_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_release k=%0d setn=%b/1 rdy=%b/%b done=%b/0", k, lat_setn,
                         wr_ready, (k == R), set_done);
            end
        end
        q_ref = 8'hFF;
    endtask

    task automatic test_directed();
        do_write(8'hA5, 8'hFF, "write_a5");
        do_preset("preset_ff");
        do_write(8'h00, 8'h0F, "write_low_nibble");
        checks++;
        if (mq !== 8'hF0) begin
            errors++;
            $display("FAIL low_nibble_q got %h exp f0", mq);
        end
        do_write(8'h5A, 8'h00, "write_mask0");
    endtask

    task automatic test_collision();
        logic [7:0] d_before;
        d_before = lat_d;
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        wr_mask  = 8'hFF;
        do_preset("collision_preset");
        checks++;
        if (lat_d !== d_before) begin
            errors++;
            $display("FAIL collision_not_accepted d got %h exp %h", lat_d, d_before);
        end
        do_write(8'h3C, 8'hFF, "collision_held_write");
        checks++;
        if (set_done !== 1'b0) begin
            errors++;
            $display("FAIL set_done_one_cycle got %b exp 0", set_done);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, m;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 4) == 0) begin
                wr_valid = ($urandom_range(0, 1) == 1);
                wr_data  = $urandom;
                do_preset("rand_preset");
                wr_valid = 1'b0;
            end else begin
                d = $urandom;
                m = $urandom;
                do_write(d, m, "rand_write");
            end
        end
`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_chk_err got %b exp 0", chk_err);
        end
`endif
    endtask

    task automatic test_reset_mid_pulse();
        wait_ready(20, "midrst");
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        wr_mask  = 8'hFF;
        tick();
        wr_valid = 1'b0;
        repeat (S) tick();
        checks++;
        if (lat_e !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_in_pulse e got %h exp ff", lat_e);
        end
        RN = 1'b0;
        #1;
        checks++;
        if (lat_e !== 8'h00 || lat_setn !== 1'b0 || mq !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_immediate e=%h/00 setn=%b/0 q=%h/ff", lat_e, lat_setn, mq);
        end
        repeat (2) tick();
        RN = 1'b1;
        wait_ready(R + 2, "midrst_release");
        q_ref = 8'hFF;
        checks++;
        if (mq !== 8'hFF || viol !== 0) begin
            errors++;
            $display("FAIL midrst_after q=%h/ff violations=%0d/0", mq, viol);
        end
    endtask

`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
    task automatic test_check();
        stuck = 1'b1;
        do_write(8'hFF, 8'hFF, "chk_write");
        checks++;
        if (chk_err !== 1'b1) begin
            errors++;
            $display("FAIL chk_err_set got %b exp 1", chk_err);
        end
        repeat (4) tick();
        stuck = 1'b0;
        do_write(8'h00, 8'h01, "chk_write2");
        checks++;
        if (chk_err !== 1'b1) begin
            errors++;
            $display("FAIL chk_err_sticky got %b exp 1", chk_err);
        end
        RN = 1'b0;
        #1;
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_err_reset got %b exp 0", chk_err);
        end
        tick();
        RN = 1'b1;
        wait_ready(R + 2, "chk_release");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_collision();
        test_random();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL timing_violations got %0d exp 0", viol);
        end
        test_reset_mid_pulse();
`ifdef LATSNQ_BANK_WRCTL_CHECK_EN
        test_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
